// File: rtl/fwd_scoreboard.sv
// Forwarding/interlock scoreboard at EX entry: per-operand bypass selects and load-use stall.
// Optional FWD_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module fwd_scoreboard #(
    parameter  int NUM_STAGES = 2,
    parameter  int REG_AW     = 5,
    parameter  int LAT_W      = 2,
    localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [REG_AW-1:0]     issue_rs,
    input  logic [REG_AW-1:0]     issue_rt,
    input  logic                  issue_use_rs,
    input  logic                  issue_use_rt,
    input  logic                  issue_we,
    input  logic [REG_AW-1:0]     issue_rd,
    input  logic [LAT_W-1:0]      issue_lat,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic [NUM_STAGES-1:0] occupancy
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    // Tracker entry per stage: index 1 is youngest (one cycle past issue).
    logic              v_q   [1:NUM_STAGES];
    logic [REG_AW-1:0] rd_q  [1:NUM_STAGES];
    logic [SEL_W-1:0]  rdy_q [1:NUM_STAGES];

    logic              stall_req_a;
    logic              stall_req_b;
    logic [SEL_W-1:0]  lat_eff;
    logic              insert;

    // Returns {stall_request, select}; only the youngest matching stage is considered.
    function automatic logic [SEL_W:0] resolve(input logic used, input logic [REG_AW-1:0] r);
        logic             found;
        logic             req;
        logic [SEL_W-1:0] sel;
        found = 1'b0;
        req   = 1'b0;
        sel   = '0;
        if (used && r != '0) begin
            for (int s = 1; s <= NUM_STAGES; s++) begin
                if (!found && v_q[s] && rd_q[s] == r) begin
                    found = 1'b1;
                    if (rdy_q[s] <= SEL_W'(s)) sel = SEL_W'(s);
                    else                       req = 1'b1;
                end
            end
        end
        return {req, sel};
    endfunction

    always_comb begin
        {stall_req_a, fwd_a_sel} = resolve(issue_use_rs, issue_rs);
        {stall_req_b, fwd_b_sel} = resolve(issue_use_rt, issue_rt);
        stall = issue_valid & ~flush & (stall_req_a | stall_req_b);
    end

    always_comb begin
        // NOTE: every branch assigns lat_eff so no latch is inferred.
        if (issue_lat == '0)
            lat_eff = SEL_W'(1);
        else if (int'(issue_lat) > NUM_STAGES)
            lat_eff = SEL_W'(NUM_STAGES);
        else
            lat_eff = SEL_W'(issue_lat);
    end

    assign insert = issue_valid & ~stall & ~flush & issue_we & (issue_rd != '0);

    always_comb begin
        occupancy = '0;
        for (int s = 1; s <= NUM_STAGES; s++) occupancy[s-1] = v_q[s];
    end

    // Reset clears every entry (tiny register array, not a RAM), including mid-stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= NUM_STAGES; s++) begin
                v_q[s]   <= 1'b0;
                rd_q[s]  <= '0;
                rdy_q[s] <= '0;
            end
        end else if (!hold) begin
            for (int s = NUM_STAGES; s >= 2; s--) begin
                v_q[s]   <= v_q[s-1];
                rd_q[s]  <= rd_q[s-1];
                rdy_q[s] <= rdy_q[s-1];
            end
            v_q[1]   <= insert;
            rd_q[1]  <= issue_rd;
            rdy_q[1] <= lat_eff;
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && !hold && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: an age-based reference model predicts outputs per cycle,
// a monitor pops the predictions and compares them at the falling edge.
module tb_fwd_scoreboard;

    localparam int N     = 2;
    localparam int AW    = 5;
    localparam int LW    = 2;
    localparam int SEL_W = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            hold = 1'b0, flush = 1'b0;
    logic            issue_valid = 1'b0;
    logic [AW-1:0]   issue_rs = '0, issue_rt = '0, issue_rd = '0;
    logic            issue_use_rs = 1'b0, issue_use_rt = 1'b0, issue_we = 1'b0;
    logic [LW-1:0]   issue_lat = '0;
    logic            stall;
    logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;
    logic [N-1:0]    occupancy;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    fwd_scoreboard #(.NUM_STAGES(N), .REG_AW(AW), .LAT_W(LW)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .issue_we(issue_we), .issue_rd(issue_rd), .issue_lat(issue_lat),
        .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .occupancy(occupancy)
`ifdef FWD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        int age;
        int rdy;
    } rec_t;

    typedef struct {
        int          tag;
        bit          stall;
        int          sel_a;
        int          sel_b;
        int          occ;
        int unsigned cnt;
    } exp_t;

    rec_t        recs[$];
    exp_t        exp_q[$];
    int unsigned m_cnt = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          tag = 0;

    task automatic check(string name, int t, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s @step %0d: got %0h expected %0h", name, t, act, req);
    endtask

    // Youngest in-flight producer of r decides; ready once its age reaches its latency.
    function automatic void model_lookup(input bit used, input int r, output int sel, output bit req);
        int best;
        sel  = 0;
        req  = 1'b0;
        best = -1;
        if (!used || r == 0) return;
        foreach (recs[i])
            if (recs[i].rd == r && (best < 0 || recs[i].age < recs[best].age)) best = i;
        if (best >= 0) begin
            if (recs[best].rdy <= recs[best].age) sel = recs[best].age;
            else req = 1'b1;
        end
    endfunction

    task automatic issue(bit valid, bit [AW-1:0] rs, bit urs, bit [AW-1:0] rt, bit urt,
                         bit we, bit [AW-1:0] rd, bit [LW-1:0] lat,
                         bit hold_i = 0, bit flush_i = 0, bit rst_i = 0, bit push = 1);
        exp_t e;
        bit   ra, rb;
        int   sa, sb, eff;
        rec_t nq[$];
        @(posedge clk);
        #1;
        issue_valid = valid; issue_rs = rs; issue_use_rs = urs; issue_rt = rt; issue_use_rt = urt;
        issue_we = we; issue_rd = rd; issue_lat = lat; hold = hold_i; flush = flush_i; rst = rst_i;

        model_lookup(urs, int'(rs), sa, ra);
        model_lookup(urt, int'(rt), sb, rb);
        e.tag   = tag++;
        e.stall = valid && !flush_i && (ra || rb);
        e.sel_a = sa;
        e.sel_b = sb;
        e.occ   = 0;
        foreach (recs[i]) e.occ |= 1 << (recs[i].age - 1);
        e.cnt   = m_cnt;
        if (push) exp_q.push_back(e);

        if (rst_i) begin
            recs.delete();
            m_cnt = 0;
        end else if (!hold_i) begin
            foreach (recs[i]) if (recs[i].age + 1 <= N) nq.push_back('{recs[i].rd, recs[i].age + 1, recs[i].rdy});
            recs = nq;
            eff = (lat == 0) ? 1 : ((int'(lat) > N) ? N : int'(lat));
            if (valid && !e.stall && !flush_i && we && rd != 0) recs.push_back('{int'(rd), 1, eff});
            if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", e.tag, 32'(stall), 32'(e.stall));
                check("fwd_a_sel", e.tag, 32'(fwd_a_sel), 32'(e.sel_a));
                check("fwd_b_sel", e.tag, 32'(fwd_b_sel), 32'(e.sel_b));
                check("occupancy", e.tag, 32'(occupancy), 32'(e.occ));
`ifdef FWD_STALL_CNT_EN
                check("stall_cnt", e.tag, stall_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin : driver
        // Reset cycle: outputs undefined before it, so nothing is predicted.
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Post-reset idle with rs = rt = 5.
        issue(1, 5, 1, 5, 1, 0, 0, 0);
        // ALU producer r3, consumer rs=3 (sel 1), then rt=3 (sel 2).
        issue(1, 0, 0, 0, 0, 1, 3, 1);
        issue(1, 3, 1, 0, 0, 0, 0, 0);
        issue(1, 0, 0, 3, 1, 0, 0, 0);
        // Load r4, dependant stalls once then gets sel 2.
        issue(1, 0, 0, 0, 0, 1, 4, 2);
        issue(1, 4, 1, 0, 0, 0, 0, 0);
        issue(1, 4, 1, 0, 0, 0, 0, 0);
        // ALU r7 then load r7: youngest (not ready) match stalls.
        issue(1, 0, 0, 0, 0, 1, 7, 1);
        issue(1, 0, 0, 0, 0, 1, 7, 2);
        issue(1, 0, 0, 7, 1, 0, 0, 0);
        issue(1, 0, 0, 7, 1, 0, 0, 0);
        // r0 write is never tracked.
        issue(1, 0, 0, 0, 0, 1, 0, 2);
        issue(1, 0, 1, 0, 0, 0, 0, 0);
        // Load r2, consumer held three cycles, then reset mid-hold.
        issue(1, 0, 0, 0, 0, 1, 2, 2);
        repeat (3) issue(1, 2, 1, 0, 0, 0, 0, 0, 1);
        issue(1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        issue(1, 2, 1, 0, 0, 0, 0, 0);
        // One unheld load-use stall.
        issue(1, 0, 0, 0, 0, 1, 2, 2);
        issue(1, 2, 1, 0, 0, 0, 0, 0);
        issue(1, 2, 1, 0, 0, 0, 0, 0);
        // Flush with hold, lat 0 and lat 3 clamping.
        issue(1, 0, 0, 0, 0, 1, 6, 0);
        issue(1, 0, 0, 0, 0, 1, 5, 3);
        issue(1, 5, 1, 6, 1, 0, 0, 0, 1, 1);
        issue(1, 5, 1, 6, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            issue(($urandom % 4) != 0, AW'($urandom % 8), $urandom % 2, AW'($urandom % 8), $urandom % 2,
                  $urandom % 2, AW'($urandom % 8), LW'($urandom % 4),
                  ($urandom % 8) == 0, ($urandom % 10) == 0, ($urandom % 60) == 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) check("drain", -1, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
